xdiv: RTL and testbench

XDIV -- requirements
Module: xdiv

---
 rtl/xdiv_if.sv | 33 +++
 rtl/xdiv.sv | 153 +++++++++++++++
 tb/tb_xdiv.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xdiv_if.sv
// xdiv_if -- handshake and data bundle for the xdiv divider.
//   start     : request to begin a division (master -> slave)
//   sgn       : 1 = signed two's-complement, 0 = unsigned (sampled with start)
//   op_a      : dividend (sampled with start)
//   op_b      : divisor (sampled with start)
//   busy      : division in progress (slave -> master)
//   done      : one-cycle pulse, results valid
//   quotient  : registered quotient
//   remainder : registered remainder
//   dbz       : registered divide-by-zero flag of the last completed division
interface xdiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              sgn;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              dbz;

  modport master (
    output start, sgn, op_a, op_b,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, sgn, op_a, op_b,
    output busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/xdiv.sv
// xdiv -- iterative restoring divider, signed or unsigned, fixed latency.
// One quotient bit is produced per clock (MSB first) on operand magnitudes;
// a final FIX cycle applies sign correction and registers the results.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : xdiv_if.slave (start/sgn/op_a/op_b in; busy/done/quotient/remainder/dbz out)
module xdiv #(
  parameter int DATA_W = 32
) (
  input logic   clk,
  input logic   rst,
  xdiv_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_sgn;
  logic              r_a_neg;   // dividend negative (signed mode only)
  logic              r_b_neg;   // divisor negative (signed mode only)
  logic              r_b_zero;
  logic [DATA_W-1:0] r_a_raw;   // original dividend, returned on divide-by-zero
  logic [DATA_W-1:0] r_div;     // divisor magnitude
  logic [DATA_W-1:0] r_rem;     // partial remainder
  logic [DATA_W-1:0] r_quo;     // dividend shifts out the top, quotient bits enter the bottom
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_q_out;
  logic [DATA_W-1:0] r_r_out;
  logic              r_dbz;

  logic              w_a_in_neg;
  logic              w_b_in_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;
  logic              w_last;
  logic [DATA_W-1:0] w_q_fix;
  logic [DATA_W-1:0] w_r_fix;

  // Operand magnitudes at the start request.
  assign w_a_in_neg = bus.sgn & bus.op_a[DATA_W-1];
  assign w_b_in_neg = bus.sgn & bus.op_b[DATA_W-1];
  assign w_a_mag    = w_a_in_neg ? (~bus.op_a + 1'b1) : bus.op_a;
  assign w_b_mag    = w_b_in_neg ? (~bus.op_b + 1'b1) : bus.op_b;

  // One restoring step. The shifted remainder is always below twice the
  // divisor, so bit DATA_W of the difference is a reliable sign.
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_ge    = ~w_diff[DATA_W];
  assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));

  // Sign correction. Divide-by-zero bypasses it: all-ones quotient and the
  // untouched dividend. The -2^(N-1) / -1 case needs no special handling:
  // magnitude 2^(N-1) with equal signs already reads back as -2^(N-1).
  always_comb begin
    w_q_fix = r_quo;
    w_r_fix = r_rem;
    if (r_b_zero) begin
      w_q_fix = '1;
      w_r_fix = r_a_raw;
    end else begin
      if (r_a_neg ^ r_b_neg) w_q_fix = ~r_quo + 1'b1;
      if (r_a_neg)           w_r_fix = ~r_rem + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = CALC;
      CALC:    if (w_last)    w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sgn    <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_a_raw  <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_q_out  <= '0;
      r_r_out  <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sgn    <= bus.sgn;
            r_a_neg  <= w_a_in_neg;
            r_b_neg  <= w_b_in_neg;
            r_b_zero <= (bus.op_b == '0);
            r_a_raw  <= bus.op_a;
            r_div    <= w_b_mag;
            r_quo    <= w_a_mag;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
          r_quo <= {r_quo[DATA_W-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          // busy drops as FIX is entered so FIX is visibly a non-busy cycle.
          if (w_last) r_busy <= 1'b0;
        end
        FIX: begin
          r_q_out <= w_q_fix;
          r_r_out <= w_r_fix;
          r_dbz   <= r_b_zero;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_q_out;
  assign bus.remainder = r_r_out;
  assign bus.dbz       = r_dbz;

endmodule

// File: tb/tb_xdiv.sv
// tb_xdiv -- self-checking bench for xdiv (DATA_W = 32).
// A transaction-level model predicts every accepted division from plain
// integer arithmetic and the fixed 33-cycle latency; a compare process checks
// all outputs on every falling edge. Directed scenarios add literal checks.
module tb_xdiv;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;

  xdiv_if #(.DATA_W(W)) bus ();

  xdiv #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {dbz, quotient, remainder} from 64-bit integer division
  // (truncating toward zero, remainder takes the dividend's sign).
  function automatic logic [2*W:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, q[W-1:0], r[W-1:0]};
  endfunction

  // ---------------- transaction model ----------------
  int             m_n = 0;        // rising edges seen
  logic           m_pending = 1'b0;
  int             m_done_edge = 0;
  logic           m_done = 1'b0;
  logic [W-1:0]   m_q = '0;
  logic [W-1:0]   m_r = '0;
  logic           m_dbz = 1'b0;
  logic [2*W:0]   m_job = '0;
  logic [W-1:0]   m_ja = '0;
  logic [W-1:0]   m_jb = '0;
  logic           m_js = 1'b0;
  int             m_jobs = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 1'b0;
      m_done    <= 1'b0;
      m_q       <= '0;
      m_r       <= '0;
      m_dbz     <= 1'b0;
    end else begin
      m_n    <= m_n + 1;
      m_done <= 1'b0;
      if (m_pending && m_n == m_done_edge) begin
        m_pending <= 1'b0;
        m_done    <= 1'b1;
        m_dbz     <= m_job[2*W];
        m_q       <= m_job[2*W-1:W];
        m_r       <= m_job[W-1:0];
        m_jobs    <= m_jobs + 1;
      end else if (!m_pending && bus.start) begin
        m_pending   <= 1'b1;
        m_done_edge <= m_n + LAT;
        m_job       <= ref_div(bus.sgn, bus.op_a, bus.op_b);
        m_ja        <= bus.op_a;
        m_jb        <= bus.op_b;
        m_js        <= bus.sgn;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("busy", W'(bus.busy), W'(m_pending && (m_n < m_done_edge)));
    chk("done", W'(bus.done), W'(m_done));
    chk("quotient", bus.quotient, m_q);
    chk("remainder", bus.remainder, m_r);
    chk("dbz", W'(bus.dbz), W'(m_dbz));
    if (m_done) begin
      $display("op %0d sgn=%0d a=%h b=%h -> q=%h r=%h dbz=%0d",
               m_jobs, m_js, m_ja, m_jb, bus.quotient, bus.remainder, bus.dbz);
      if (m_jb != '0) chk("identity", bus.quotient * m_jb + bus.remainder, m_ja);
    end
  end

  // ---------------- driver ----------------
  // Waits (bounded) for done, counting busy cycles; lat is the number of
  // falling edges after the sampling edge, -1 on timeout.
  task automatic collect(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
    int lat;
    int bc;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.sgn = s; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
    collect(lat, bc);
    chk("lit_latency", W'(lat), W'(LAT));
    chk("lit_busy_cycles", W'(bc), W'(W));
    chk("lit_q", bus.quotient, eq);
    chk("lit_r", bus.remainder, er);
    chk("lit_dbz", W'(bus.dbz), W'(ed));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 15))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(1, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    int bc;
    logic [2*W:0] rv;

    bus.start = 1'b0; bus.sgn = 1'b0; bus.op_a = '0; bus.op_b = '0;

    // Pin the reference model with hand-computed values.
    rv = ref_div(1'b0, 32'd100, 32'd7);
    chk("model_u", rv[2*W-1:W] ^ rv[W-1:0], 32'd14 ^ 32'd2);
    rv = ref_div(1'b1, -32'sd100, 32'd7);
    chk("model_sq", rv[2*W-1:W], 32'hFFFF_FFF2);
    chk("model_sr", rv[W-1:0], 32'hFFFF_FFFE);
    rv = ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("model_ovf", rv[2*W-1:W], 32'h8000_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", W'(bus.busy), '0);
    chk("reset_done", W'(bus.done), '0);
    chk("reset_q", bus.quotient, '0);
    chk("reset_r", bus.remainder, '0);
    chk("reset_dbz", W'(bus.dbz), '0);
    @(posedge clk); #2;
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op(1'b1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_op(1'b1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0);
    run_op(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.sgn = 1'b0; bus.op_a = 32'd1000; bus.op_b = 32'd3;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (4) @(posedge clk); #2;
    bus.start = 1'b1; bus.op_a = 32'd77; bus.op_b = 32'd5;
    @(posedge clk); #2;
    bus.start = 1'b0;
    collect(lat, bc);
    chk("ign_seen_done", W'(lat >= 0), W'(1));
    chk("ign_q", bus.quotient, 32'd333);
    chk("ign_r", bus.remainder, 32'd1);
    bus.start = 1'b1; bus.op_a = 32'd50; bus.op_b = 32'd6;
    @(posedge clk); #2;
    bus.start = 1'b0;
    collect(lat, bc);
    chk("b2b_latency", W'(lat), W'(LAT));
    chk("b2b_q", bus.quotient, 32'd8);
    chk("b2b_r", bus.remainder, 32'd2);

    // Reset in the middle of CALC.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.sgn = 1'b0; bus.op_a = 32'd1000; bus.op_b = 32'd7;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (9) @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_q", bus.quotient, '0);
    chk("rst_r", bus.remainder, '0);
    chk("rst_dbz", W'(bus.dbz), '0);
    @(posedge clk); #2;
    rst = 1'b0;
    bus.start = 1'b1; bus.op_a = 32'd15; bus.op_b = 32'd4;
    @(posedge clk); #2;
    bus.start = 1'b0;
    collect(lat, bc);
    chk("post_rst_latency", W'(lat), W'(LAT));
    chk("post_rst_q", bus.quotient, 32'd3);
    chk("post_rst_r", bus.remainder, 32'd3);

    // Random traffic, start asserted most cycles so back-to-back and
    // ignored starts occur constantly.
    repeat (42000) begin
      @(posedge clk); #2;
      bus.start = ($urandom_range(0, 9) != 0);
      bus.sgn   = 1'($urandom_range(0, 1));
      bus.op_a  = pick();
      bus.op_b  = pick();
    end
    bus.start = 1'b0;
    repeat (LAT + 5) @(posedge clk);
    chk("random_jobs_min", W'(m_jobs > 1000), W'(1));
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
